// File: rtl/avalon_pio_in_irq.sv
// Avalon-MM parallel input port with per-bit synchroniser, debounce,
// edge capture (write-1-to-clear) and maskable level interrupt.
module avalon_pio_in_irq #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1
                      : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [CW-1:0]                     r_cnt [WIDTH];
    logic [WIDTH-1:0]                  r_deb;
    logic [WIDTH-1:0]                  r_deb_d;
    logic [WIDTH-1:0]                  r_mask;
    logic [WIDTH-1:0]                  r_cap;

    logic [WIDTH-1:0] w_synced;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_evt;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rd;
    logic             w_unused_wd;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
        end
    end

    // Counter runs only while synced disagrees with the accepted level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_deb_d <= r_deb;
            for (int i = 0; i < WIDTH; i++) begin
                if (w_synced[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= w_synced[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_rise = r_deb & ~r_deb_d;
    assign w_fall = ~r_deb & r_deb_d;
    assign w_evt  = (EDGE_TYPE == 0) ? w_rise
                  : (EDGE_TYPE == 1) ? w_fall
                  : (w_rise | w_fall);

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == 2'd3)
                 ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (w_wr && address == 2'd2) begin
            r_mask <= writedata[WIDTH-1:0];
        end
    end

    // New events are OR'd in after the clear so a coincident set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap <= '0;
        end else begin
            r_cap <= (r_cap & ~w_clr) | w_evt;
        end
    end

    always_comb begin
        w_rd = '0;
        unique case (address)
            2'd0: w_rd[WIDTH-1:0] = r_deb;
            2'd1: w_rd            = '0;
            2'd2: w_rd[WIDTH-1:0] = r_mask;
            2'd3: w_rd[WIDTH-1:0] = r_cap;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd;
        end
    end

    assign irq = |(r_cap & r_mask);

    assign w_unused_wd = ^writedata;

endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// Directed bench for avalon_pio_in_irq: three instances share one bus
// and exercise rising, any-edge and narrow/falling configurations.
module tb_avalon_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in0;
    logic [7:0]  in1;
    logic [4:0]  in2;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        irq0;
    logic        irq1;
    logic        irq2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    avalon_pio_in_irq #(
        .WIDTH(8), .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0)
    );

    avalon_pio_in_irq #(
        .WIDTH(8), .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in1),
        .readdata(rd1), .irq(irq1)
    );

    avalon_pio_in_irq #(
        .WIDTH(5), .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1)
    ) u2 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in2),
        .readdata(rd2), .irq(irq2)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in0        = '0;
        in1        = '0;
        in2        = '0;

        // reset state
        tick(3);
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_rd2", rd2, 32'h0);
        chk("rst_irq0", {31'b0, irq0}, 32'h0);
        reset_n = 1'b1;

        // rising edge on bit 0, latency 7 edges
        wr(2'd2, 32'h1);
        in0[0] = 1'b1;
        tick(6);
        chk("rise_early_irq", {31'b0, irq0}, 32'h0);
        tick(1);
        chk("rise_irq", {31'b0, irq0}, 32'h1);
        rd(2'd0);
        chk("rise_deb", rd0, 32'h1);
        rd(2'd3);
        chk("rise_cap", rd0, 32'h1);

        // 3-cycle glitch on bit 1 is filtered
        in0[1] = 1'b1;
        tick(3);
        in0[1] = 1'b0;
        tick(10);
        rd(2'd0);
        chk("glitch_deb", rd0, 32'h1);
        rd(2'd3);
        chk("glitch_cap", rd0, 32'h1);

        // clear collides with new rising edge: set wins
        in0[0] = 1'b0;
        tick(10);
        in0[0] = 1'b1;
        tick(6);
        address    = 2'd3;
        writedata  = 32'h1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        chk("coll_irq", {31'b0, irq0}, 32'h1);
        rd(2'd3);
        chk("coll_cap", rd0, 32'h1);
        wr(2'd3, 32'h1);
        chk("clr_irq", {31'b0, irq0}, 32'h0);
        rd(2'd3);
        chk("clr_cap", rd0, 32'h0);

        // any-edge instance, masked then unmasked
        wr(2'd2, 32'h0);
        in1[2] = 1'b1;
        tick(10);
        in1[2] = 1'b0;
        tick(10);
        rd(2'd3);
        chk("any_cap", rd1, 32'h4);
        chk("any_irq_masked", {31'b0, irq1}, 32'h0);
        wr(2'd2, 32'h4);
        chk("any_irq", {31'b0, irq1}, 32'h1);
        chk("any_u0_irq", {31'b0, irq0}, 32'h0);

        // narrow instance register widths
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2);
        chk("w5_mask", rd2, 32'h1F);
        chk("w8_mask", rd0, 32'hFF);
        rd(2'd1);
        chk("w5_addr1", rd2, 32'h0);
        chk("w8_addr1", rd0, 32'h0);
        wr(2'd0, 32'hFF);
        rd(2'd0);
        chk("w5_ro", rd2, 32'h0);
        chk("w8_ro", rd0, 32'h1);

        // falling-only instance with single-cycle debounce
        in2[4] = 1'b1;
        tick(8);
        chk("fall_rise_irq", {31'b0, irq2}, 32'h0);
        in2[4] = 1'b0;
        tick(3);
        chk("fall_early_irq", {31'b0, irq2}, 32'h0);
        tick(1);
        chk("fall_irq", {31'b0, irq2}, 32'h1);
        rd(2'd3);
        chk("fall_cap", rd2, 32'h10);

        // reset mid-debounce with inputs held high
        in0 = 8'hFF;
        tick(3);
        reset_n = 1'b0;
        tick(2);
        chk("mid_rst_rd2", rd2, 32'h0);
        chk("mid_rst_irq1", {31'b0, irq1}, 32'h0);
        chk("mid_rst_irq2", {31'b0, irq2}, 32'h0);
        reset_n = 1'b1;
        wr(2'd2, 32'hFF);
        tick(5);
        chk("post_rst_early", {31'b0, irq0}, 32'h0);
        tick(1);
        chk("post_rst_irq", {31'b0, irq0}, 32'h1);
        rd(2'd3);
        chk("post_rst_cap", rd0, 32'hFF);
        chk("post_rst_cap1", rd1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
